// File: rtl/n_wb_arbiter_pkg.sv
// Shared widths, select encodings and grant type for the NPU write-back arbiter.
// Stands in for the legacy defs.v constants (`Sel_NPU_ALU, register address/data widths).
package n_wb_arbiter_pkg;

    localparam int   REG_ADDR_W  = 5;
    localparam int   REG_DATA_W  = 8;
    localparam logic SEL_NPU_ALU = 1'b1;
    localparam logic SEL_CPU_ALU = 1'b0;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_CPU    = 2'd1,
        GNT_FIFO   = 2'd2,
        GNT_BYPASS = 2'd3
    } grant_e;

endpackage

// File: rtl/n_wb_fifo.sv
// NPU write buffer: circular FIFO of (address, data) with per-entry address match.
module n_wb_fifo
    import n_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_addr_i,
    input  logic [REG_DATA_W-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic [REG_ADDR_W-1:0] match_addr_i,
    output logic [REG_ADDR_W-1:0] head_addr_o,
    output logic [REG_DATA_W-1:0] head_data_o,
    output logic [3:0]            count_o,
    output logic [DEPTH-1:0]      match_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [3:0]            r_count;
    logic [REG_ADDR_W-1:0] r_addr [DEPTH];
    logic [REG_DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      w_off;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_addr[r_wr_ptr] <= push_addr_i;
            r_data[r_wr_ptr] <= push_data_i;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        w_off   = '0;
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PTR_W'(i) - r_rd_ptr;
            match_o[i] = (4'(w_off) < r_count) && (r_addr[i] == match_addr_i);
        end
    end

    assign head_addr_o = r_addr[r_rd_ptr];
    assign head_data_o = r_data[r_rd_ptr];
    assign count_o     = r_count;

endmodule

// File: rtl/n_wb_arbiter.sv
// Register-file write-port arbiter between CPU ALU writes and buffered NPU writes.
// Define NPU_WB_STARVE_EN to enable forced draining of an NPU write waiting MAX_WAIT cycles.
module n_wb_arbiter
    import n_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_w_reg_i,
    input  logic [REG_ADDR_W-1:0] w_reg_addr_1_i,
    input  logic [REG_DATA_W-1:0] w_reg_data_1_i,
    input  logic                  en_w_reg_npu_i,
    input  logic [REG_ADDR_W-1:0] w_reg_addr_npu_i,
    input  logic [REG_DATA_W-1:0] w_reg_data_npu_i,
    output logic                  npu_ready_o,
    output logic                  cpu_stall_o,
    output logic                  en_w_reg_o,
    output logic [REG_ADDR_W-1:0] w_reg_addr_1_o,
    output logic [REG_DATA_W-1:0] w_reg_data_1_o,
    output logic                  npu_alu_sel_o,
    output logic [3:0]            fifo_count_o
);
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        $error("FIFO_DEPTH must be a power of two in 2..8");
    if (MAX_WAIT < 1)
        $error("MAX_WAIT must be at least 1");

    logic [3:0]            w_count;
    logic [REG_ADDR_W-1:0] w_head_addr;
    logic [REG_DATA_W-1:0] w_head_data;
    logic [FIFO_DEPTH-1:0] w_match;
    logic                  w_empty;
    logic                  w_ready;
    logic                  w_hazard;
    logic                  w_force;
    logic                  w_push;
    logic                  w_pop;
    grant_e                w_grant;

    assign w_empty  = (w_count == 4'd0);
    assign w_ready  = rst_n_i && (w_count < 4'(FIFO_DEPTH));
    assign w_hazard = en_w_reg_i && (|w_match);

`ifdef NPU_WB_STARVE_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] r_wait_cnt;

    assign w_force = !w_empty && (r_wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_wait_cnt <= '0;
        else if (w_pop || w_empty)
            r_wait_cnt <= '0;
        else if (r_wait_cnt != WAIT_W'(MAX_WAIT))
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
`else
    assign w_force = 1'b0;
`endif

    // FORCE and address hazards both fall through to draining the FIFO head.
    always_comb begin
        w_grant = GNT_NONE;
        if (en_w_reg_i && !w_force && !w_hazard)
            w_grant = GNT_CPU;
        else if (!w_empty)
            w_grant = GNT_FIFO;
        else if (en_w_reg_npu_i)
            w_grant = GNT_BYPASS;
    end

    assign w_pop  = rst_n_i && (w_grant == GNT_FIFO);
    assign w_push = en_w_reg_npu_i && w_ready && (w_grant != GNT_BYPASS);

    n_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (w_push),
        .push_addr_i  (w_reg_addr_npu_i),
        .push_data_i  (w_reg_data_npu_i),
        .pop_i        (w_pop),
        .match_addr_i (w_reg_addr_1_i),
        .head_addr_o  (w_head_addr),
        .head_data_o  (w_head_data),
        .count_o      (w_count),
        .match_o      (w_match)
    );

    always_comb begin
        en_w_reg_o     = 1'b0;
        w_reg_addr_1_o = '0;
        w_reg_data_1_o = '0;
        npu_alu_sel_o  = SEL_CPU_ALU;
        if (rst_n_i) begin
            unique case (w_grant)
                GNT_CPU: begin
                    en_w_reg_o     = 1'b1;
                    w_reg_addr_1_o = w_reg_addr_1_i;
                    w_reg_data_1_o = w_reg_data_1_i;
                end
                GNT_FIFO: begin
                    en_w_reg_o     = 1'b1;
                    w_reg_addr_1_o = w_head_addr;
                    w_reg_data_1_o = w_head_data;
                    npu_alu_sel_o  = SEL_NPU_ALU;
                end
                GNT_BYPASS: begin
                    en_w_reg_o     = 1'b1;
                    w_reg_addr_1_o = w_reg_addr_npu_i;
                    w_reg_data_1_o = w_reg_data_npu_i;
                    npu_alu_sel_o  = SEL_NPU_ALU;
                end
                default: ;
            endcase
        end
    end

    assign cpu_stall_o  = rst_n_i && en_w_reg_i && (w_grant != GNT_CPU);
    assign npu_ready_o  = w_ready;
    assign fifo_count_o = w_count;

endmodule

// File: tb/tb_n_wb_arbiter.sv
// Directed bench for n_wb_arbiter; observed vector is {ready, count, en, stall, sel, addr, data}.
// Expectations for the starvation scenario follow NPU_WB_STARVE_EN.
module tb_n_wb_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_w_reg_i = 1'b0;
    logic [4:0] w_reg_addr_1_i = '0;
    logic [7:0] w_reg_data_1_i = '0;
    logic       en_w_reg_npu_i = 1'b0;
    logic [4:0] w_reg_addr_npu_i = '0;
    logic [7:0] w_reg_data_npu_i = '0;
    logic       npu_ready_o;
    logic       cpu_stall_o;
    logic       en_w_reg_o;
    logic [4:0] w_reg_addr_1_o;
    logic [7:0] w_reg_data_1_o;
    logic       npu_alu_sel_o;
    logic [3:0] fifo_count_o;

    logic [20:0] obs;
    int checks = 0;
    int failures = 0;

    n_wb_arbiter #(.FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .en_w_reg_i       (en_w_reg_i),
        .w_reg_addr_1_i   (w_reg_addr_1_i),
        .w_reg_data_1_i   (w_reg_data_1_i),
        .en_w_reg_npu_i   (en_w_reg_npu_i),
        .w_reg_addr_npu_i (w_reg_addr_npu_i),
        .w_reg_data_npu_i (w_reg_data_npu_i),
        .npu_ready_o      (npu_ready_o),
        .cpu_stall_o      (cpu_stall_o),
        .en_w_reg_o       (en_w_reg_o),
        .w_reg_addr_1_o   (w_reg_addr_1_o),
        .w_reg_data_1_o   (w_reg_data_1_o),
        .npu_alu_sel_o    (npu_alu_sel_o),
        .fifo_count_o     (fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {npu_ready_o, fifo_count_o, en_w_reg_o, cpu_stall_o, npu_alu_sel_o,
                  w_reg_addr_1_o, w_reg_data_1_o};

    task automatic drive(input logic ce, input logic [4:0] ca, input logic [7:0] cd,
                         input logic ne, input logic [4:0] na, input logic [7:0] nd);
        en_w_reg_i = ce; w_reg_addr_1_i = ca; w_reg_data_1_i = cd;
        en_w_reg_npu_i = ne; w_reg_addr_npu_i = na; w_reg_data_npu_i = nd;
        #1;
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        logic [20:0] exp;
        drive(1'b1, 5'd1, 8'h01, 1'b1, 5'd2, 8'h02);
        exp = 21'h0;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, exp); end
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        rst_n_i = 1'b1;
        step();
        exp = {1'b1, 4'd0, 16'd0};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_bypass;
        logic [20:0] exp;
        drive(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 8'h5A);
        exp = {1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 5'd3, 8'h5A};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL bypass_write got=%h exp=%h", obs, exp); end
        step();
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        exp = {1'b1, 4'd0, 16'd0};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL bypass_after got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_cpu_and_npu;
        logic [20:0] exp;
        drive(1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22);
        exp = {1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 5'd1, 8'h11};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cpu_npu_cpu got=%h exp=%h", obs, exp); end
        step();
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        exp = {1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 5'd2, 8'h22};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cpu_npu_drain got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 4'd0, 16'd0};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cpu_npu_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_full;
        logic [20:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(10 + i), 8'(8'hC0 + i), 1'b1, 5'(20 + i), 8'(8'hA0 + i));
            exp = {(i < 4), 4'(i), 1'b1, 1'b0, 1'b0, 5'(10 + i), 8'(8'hC0 + i)};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL full_fill[%0d] got=%h exp=%h", i, obs, exp); end
            step();
        end
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        for (int j = 0; j < 4; j++) begin
            exp = {(j > 0), 4'(4 - j), 1'b1, 1'b0, 1'b1, 5'(20 + j), 8'(8'hA0 + j)};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", j, obs, exp); end
            step();
        end
        exp = {1'b1, 4'd0, 16'd0};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL full_empty got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_hazard;
        logic [20:0] exp;
        drive(1'b1, 5'd5, 8'h55, 1'b1, 5'd7, 8'h77);
        exp = {1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 5'd5, 8'h55};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hazard_push got=%h exp=%h", obs, exp); end
        step();
        drive(1'b1, 5'd7, 8'h70, 1'b0, 5'd0, 8'h00);
        exp = {1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 5'd7, 8'h77};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hazard_stall got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 5'd7, 8'h70};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hazard_cpu_next got=%h exp=%h", obs, exp); end
        step();
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic test_starve;
        logic [20:0] exp;
        drive(1'b1, 5'd1, 8'h01, 1'b1, 5'd9, 8'h99);
        exp = {1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 5'd1, 8'h01};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL starve_push got=%h exp=%h", obs, exp); end
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 5'(16 + k), 8'(k), 1'b0, 5'd0, 8'h00);
            exp = {1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 5'(16 + k), 8'(k)};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL starve_cpu[%0d] got=%h exp=%h", k, obs, exp); end
            step();
        end
        drive(1'b1, 5'd30, 8'h30, 1'b0, 5'd0, 8'h00);
`ifdef NPU_WB_STARVE_EN
        exp = {1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 5'd9, 8'h99};
`else
        exp = {1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 5'd30, 8'h30};
`endif
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL starve_ninth got=%h exp=%h", obs, exp); end
        step();
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
`ifdef NPU_WB_STARVE_EN
        exp = {1'b1, 4'd0, 16'd0};
`else
        exp = {1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 5'd9, 8'h99};
`endif
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL starve_after got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 4'd0, 16'd0};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL starve_empty got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_reset_mid;
        logic [20:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(1 + i), 8'(8'h10 + i), 1'b1, 5'(20 + i), 8'(8'hB0 + i));
            exp = {1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 5'(1 + i), 8'(8'h10 + i)};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL rmid_fill[%0d] got=%h exp=%h", i, obs, exp); end
            step();
        end
        drive(1'b1, 5'd4, 8'h14, 1'b0, 5'd0, 8'h00);
        exp = {1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 5'd4, 8'h14};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rmid_count3 got=%h exp=%h", obs, exp); end
        rst_n_i = 1'b0;
        #1;
        exp = 21'h0;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rmid_async got=%h exp=%h", obs, exp); end
        step();
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        rst_n_i = 1'b1;
        #1;
        for (int j = 0; j < 2; j++) begin
            exp = {1'b1, 4'd0, 16'd0};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL rmid_release[%0d] got=%h exp=%h", j, obs, exp); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_cpu_and_npu();
        test_full();
        test_hazard();
        test_starve();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
